// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM states, forwarding selects and PC_Src encodings for the pipeline hazard logic.
package hazard_pkg;
    typedef enum logic [1:0] {RUN, LOAD_STALL, FREEZE} state_t;
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;
    localparam logic [1:0] PCSRC_JR     = 2'b11;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, flush and freeze sequencing plus registered
// execute-stage forwarding selects for the 5-stage pipeline.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regw,
    input  logic              id_mem_r,
    input  logic [1:0]        ex_pc_src,
    input  logic              mem_busy,
    output logic              pc_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    state_t state;
    logic ex_v, ex_regw, ex_memr, mem_v, mem_regw;
    logic [REG_AW-1:0] ex_rd, mem_rd;
    logic ex_a, ex_b, mem_a, mem_b, flush, load_use, stall_inc;

    function automatic logic hit(input logic use_src, input logic [REG_AW-1:0] src,
                                 input logic v, input logic regw, input logic [REG_AW-1:0] rd);
        return use_src && src != '0 && v && regw && src == rd;
    endfunction

    assign ex_a      = hit(id_use_rs, id_rs, ex_v, ex_regw, ex_rd);
    assign ex_b      = hit(id_use_rt, id_rt, ex_v, ex_regw, ex_rd);
    assign mem_a     = hit(id_use_rs, id_rs, mem_v, mem_regw, mem_rd);
    assign mem_b     = hit(id_use_rt, id_rt, mem_v, mem_regw, mem_rd);
    assign flush     = ex_pc_src != PCSRC_SEQ;
    assign load_use  = state != LOAD_STALL && id_valid && ex_memr && (ex_a || ex_b);
    assign stall_inc = mem_busy || (!flush && load_use);
    // Gated by rst so an asserted reset silences the pipeline controls at once.
    assign pc_stall    = !rst && stall_inc;
    assign ifid_flush  = !rst && !mem_busy && flush;
    assign idex_bubble = !rst && !mem_busy && (flush || load_use);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ex_v      <= 1'b0;
            ex_rd     <= '0;
            ex_regw   <= 1'b0;
            ex_memr   <= 1'b0;
            mem_v     <= 1'b0;
            mem_rd    <= '0;
            mem_regw  <= 1'b0;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else if (mem_busy) begin
            state <= FREEZE;
        end else begin
            mem_v    <= ex_v;
            mem_rd   <= ex_rd;
            mem_regw <= ex_regw;
            if (flush || load_use) begin
                state     <= flush ? RUN : LOAD_STALL;
                ex_v      <= 1'b0;
                fwd_a_sel <= FWD_RF;
                fwd_b_sel <= FWD_RF;
            end else begin
                state     <= RUN;
                ex_v      <= id_valid;
                ex_rd     <= id_rd;
                ex_regw   <= id_regw;
                ex_memr   <= id_mem_r;
                fwd_a_sel <= (ex_a && !ex_memr) ? FWD_EXMEM : mem_a ? FWD_MEMWB : FWD_RF;
                fwd_b_sel <= (ex_b && !ex_memr) ? FWD_EXMEM : mem_b ? FWD_MEMWB : FWD_RF;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_inc), .count(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(!mem_busy && flush), .count(flush_cnt));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scenario tasks driving per-cycle rows; registered expectations go through a queue.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic id_valid, id_use_rs, id_use_rt, id_regw, id_mem_r, mem_busy;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [1:0] ex_pc_src;
    logic pc_stall, ifid_flush, idex_bubble;
    logic [1:0] fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt;
    logic [2:0] comb_obs;
    logic [7:0] reg_obs;
    int n_cmp = 0, n_bad = 0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic v; logic [4:0] rs, rt, rd; logic urs, urt, regw, memr;
        logic [1:0] pcs; logic busy; logic [2:0] ec; logic [7:0] er;
    } row_t;

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regw(id_regw),
        .id_mem_r(id_mem_r), .ex_pc_src(ex_pc_src), .mem_busy(mem_busy), .pc_stall(pc_stall),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;
    assign comb_obs = {pc_stall, ifid_flush, idex_bubble};
    assign reg_obs  = {fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt};

    task automatic apply(input row_t r);
        id_valid = r.v; id_rs = r.rs; id_rt = r.rt; id_rd = r.rd;
        id_use_rs = r.urs; id_use_rt = r.urt; id_regw = r.regw; id_mem_r = r.memr;
        ex_pc_src = r.pcs; mem_busy = r.busy;
    endtask

    task automatic do_reset();
        apply('0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply('{1, 5, 5, 6, 1, 1, 1, 1, 2, 1, 3'b000, 8'h00});
        @(negedge clk);
        #1 n_cmp++;
        if (comb_obs !== 3'b000) begin n_bad++; $display("FAIL reset_comb got %b want 000", comb_obs); end
        n_cmp++;
        if (reg_obs !== 8'h00) begin n_bad++; $display("FAIL reset_regs got %b want 00000000", reg_obs); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [7:0] e;
        do_reset();
        rows.push_back('{1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 3'b000, 8'b00_00_00_00});
        rows.push_back('{1, 3, 1, 4, 1, 1, 1, 0, 0, 0, 3'b000, 8'b01_00_00_00});
        rows.push_back('{1, 3, 4, 4, 1, 1, 1, 0, 0, 0, 3'b000, 8'b10_01_00_00});
        rows.push_back('{1, 4, 4, 9, 1, 1, 1, 0, 0, 0, 3'b000, 8'b01_01_00_00});
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 n_cmp++;
            if (comb_obs !== rows[i].ec) begin n_bad++; $display("FAIL b2b_comb[%0d] got %b want %b", i, comb_obs, rows[i].ec); end
            exp_q.push_back(rows[i].er);
            @(posedge clk);
            #1 e = exp_q.pop_front(); n_cmp++;
            if (reg_obs !== e) begin n_bad++; $display("FAIL b2b_regs[%0d] got %b want %b", i, reg_obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        logic [7:0] e;
        do_reset();
        rows.push_back('{1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 3'b000, 8'b00_00_00_00});
        rows.push_back('{1, 5, 5, 6, 1, 1, 1, 0, 0, 0, 3'b101, 8'b00_00_01_00});
        rows.push_back('{1, 5, 5, 6, 1, 1, 1, 0, 0, 0, 3'b000, 8'b10_10_01_00});
        rows.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 8'b00_00_01_00});
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 n_cmp++;
            if (comb_obs !== rows[i].ec) begin n_bad++; $display("FAIL lduse_comb[%0d] got %b want %b", i, comb_obs, rows[i].ec); end
            exp_q.push_back(rows[i].er);
            @(posedge clk);
            #1 e = exp_q.pop_front(); n_cmp++;
            if (reg_obs !== e) begin n_bad++; $display("FAIL lduse_regs[%0d] got %b want %b", i, reg_obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_priority();
        row_t rows[$];
        logic [7:0] e;
        do_reset();
        rows.push_back('{1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 3'b000, 8'b00_00_00_00});
        rows.push_back('{1, 5, 5, 6, 1, 1, 1, 0, 2, 0, 3'b011, 8'b00_00_00_01});
        rows.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 8'b00_00_00_01});
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 n_cmp++;
            if (comb_obs !== rows[i].ec) begin n_bad++; $display("FAIL flush_comb[%0d] got %b want %b", i, comb_obs, rows[i].ec); end
            exp_q.push_back(rows[i].er);
            @(posedge clk);
            #1 e = exp_q.pop_front(); n_cmp++;
            if (reg_obs !== e) begin n_bad++; $display("FAIL flush_regs[%0d] got %b want %b", i, reg_obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_freeze();
        row_t rows[$];
        logic [7:0] e;
        do_reset();
        rows.push_back('{1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 3'b000, 8'b00_00_00_00});
        rows.push_back('{1, 3, 1, 4, 1, 1, 1, 0, 0, 0, 3'b000, 8'b01_00_00_00});
        rows.push_back('{1, 4, 4, 7, 1, 1, 1, 0, 2, 1, 3'b100, 8'b01_00_01_00});
        rows.push_back('{1, 4, 4, 7, 1, 1, 1, 0, 2, 1, 3'b100, 8'b01_00_10_00});
        rows.push_back('{1, 4, 4, 7, 1, 1, 1, 0, 2, 1, 3'b100, 8'b01_00_11_00});
        rows.push_back('{1, 4, 4, 7, 1, 1, 1, 0, 2, 0, 3'b011, 8'b00_00_11_01});
        rows.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 8'b00_00_11_01});
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 n_cmp++;
            if (comb_obs !== rows[i].ec) begin n_bad++; $display("FAIL freeze_comb[%0d] got %b want %b", i, comb_obs, rows[i].ec); end
            exp_q.push_back(rows[i].er);
            @(posedge clk);
            #1 e = exp_q.pop_front(); n_cmp++;
            if (reg_obs !== e) begin n_bad++; $display("FAIL freeze_regs[%0d] got %b want %b", i, reg_obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_r0_saturation();
        row_t rows[$];
        logic [7:0] e;
        logic [1:0] sc;
        do_reset();
        rows.push_back('{1, 1, 2, 0, 1, 1, 1, 0, 0, 0, 3'b000, 8'b00_00_00_00});
        rows.push_back('{1, 0, 0, 5, 1, 1, 1, 0, 0, 0, 3'b000, 8'b00_00_00_00});
        rows.push_back('{1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'b000, 8'b00_00_00_00});
        sc = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            rows.push_back('{1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 3'b000, {4'b0000, sc, 2'b00}});
            sc = (k > 3) ? 2'd3 : 2'(k);
            rows.push_back('{1, 5, 5, 6, 1, 1, 1, 0, 0, 0, 3'b101, {4'b0000, sc, 2'b00}});
            rows.push_back('{1, 5, 5, 6, 1, 1, 1, 0, 0, 0, 3'b000, {4'b1010, sc, 2'b00}});
        end
        foreach (rows[i]) begin
            apply(rows[i]);
            #1 n_cmp++;
            if (comb_obs !== rows[i].ec) begin n_bad++; $display("FAIL r0sat_comb[%0d] got %b want %b", i, comb_obs, rows[i].ec); end
            exp_q.push_back(rows[i].er);
            @(posedge clk);
            #1 e = exp_q.pop_front(); n_cmp++;
            if (reg_obs !== e) begin n_bad++; $display("FAIL r0sat_regs[%0d] got %b want %b", i, reg_obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_stall();
        row_t rows[$];
        logic [7:0] e;
        do_reset();
        rows.push_back('{1, 1, 0, 5, 1, 0, 1, 1, 0, 0, 3'b000, 8'b00_00_00_00});
        rows.push_back('{1, 5, 5, 6, 1, 1, 1, 0, 0, 0, 3'b101, 8'b00_00_01_00});
        rows.push_back('{1, 5, 5, 7, 1, 1, 1, 0, 0, 0, 3'b000, 8'b00_00_00_00});
        foreach (rows[i]) begin
            apply(rows[i]);
            if (i == 2) begin
                #2 rst = 1'b1;
                #1 n_cmp++;
                if (comb_obs !== 3'b000) begin n_bad++; $display("FAIL midrst_comb got %b want 000", comb_obs); end
                n_cmp++;
                if (reg_obs !== 8'h00) begin n_bad++; $display("FAIL midrst_regs got %b want 00000000", reg_obs); end
                @(negedge clk);
                rst = 1'b0;
            end
            #1 n_cmp++;
            if (comb_obs !== rows[i].ec) begin n_bad++; $display("FAIL rstmid_comb[%0d] got %b want %b", i, comb_obs, rows[i].ec); end
            exp_q.push_back(rows[i].er);
            @(posedge clk);
            #1 e = exp_q.pop_front(); n_cmp++;
            if (reg_obs !== e) begin n_bad++; $display("FAIL rstmid_regs[%0d] got %b want %b", i, reg_obs, e); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_flush_priority();
        test_freeze();
        test_r0_saturation();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
